// File: rtl/rob_pkg.sv
// rob_pkg: shared types and helpers for the ROB ID allocator.
//   ROB_ID_WIDTH - index width of the default configuration.
//   ROB_DEPTH    - entries in the default configuration (2**ROB_ID_WIDTH).
//   rob_id_t     - {wrap, idx}. The wrap bit tells a full ROB from an empty one.
//   rob_id_add   - adds n to an ID, modulo 2**(ROB_ID_WIDTH+1).
package rob_pkg;

  localparam int unsigned ROB_ID_WIDTH = 3;
  localparam int unsigned ROB_DEPTH    = 1 << ROB_ID_WIDTH;

  typedef struct packed {
    logic                    wrap;
    logic [ROB_ID_WIDTH-1:0] idx;
  } rob_id_t;

  // The idx carry ripples into the wrap bit, so wrap toggles when idx rolls over.
  function automatic rob_id_t rob_id_add(rob_id_t id, int n);
    return rob_id_t'(id + (ROB_ID_WIDTH + 1)'(n));
  endfunction

endpackage

// File: rtl/rob_ptr_reg.sv
// rob_ptr_reg: a {wrap, idx} pointer register. It supports synchronous reset,
// increment by n, and load. Load has priority over increment.
//   clk_i    - clock
//   rst_i    - synchronous active-high reset; clears the pointer to 0
//   inc_i    - amount added this cycle (modulo 2**W)
//   ld_i     - load ld_val_i instead of incrementing
//   ld_val_i - value to load
//   ptr_o    - current pointer value
module rob_ptr_reg #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] inc_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] r_ptr;

  // Pointer state; addition wraps naturally at 2**W.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (ld_i) begin
      r_ptr <= ld_val_i;
    end else begin
      r_ptr <= r_ptr + inc_i;
    end
  end

  assign ptr_o = r_ptr;

endmodule

// File: rtl/rob_id_alloc.sv
// rob_id_alloc: multi-lane reorder-buffer ID allocator. Each cycle it hands out
// up to ALLOC_W consecutive IDs at the tail. Each cycle it frees up to RETIRE_W
// of the oldest IDs at the head.
// Optional feature (macro ROB_ID_PARTIAL_FLUSH_EN): adds flush_id_i. A flush
// then keeps every ID up to and including flush_id_i, instead of emptying the ROB.
//   clk_i, rst_i  - clock; synchronous active-high reset
//   alloc_vld_i   - per-lane allocation request, contiguous from lane 0
//   alloc_rdy_o   - at least ALLOC_W free slots remain
//   alloc_id_o    - lane k = tail + k, as {wrap, idx}
//   retire_cnt_i  - number of oldest IDs freed this cycle
//   flush_i       - discard un-retired IDs
//   flush_id_i    - (optional) youngest ID that survives the flush
//   head_id_o     - oldest live ID
//   tail_id_o     - next ID to allocate
//   count_o       - number of live entries, 0..DEPTH
//   full_o        - high when count_o == DEPTH
//   empty_o       - high when count_o == 0
module rob_id_alloc
  import rob_pkg::*;
#(
  parameter int unsigned ID_WIDTH = ROB_ID_WIDTH,
  parameter int unsigned ALLOC_W  = 2,
  parameter int unsigned RETIRE_W = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [ALLOC_W-1:0]               alloc_vld_i,
  output logic                             alloc_rdy_o,
  output logic [ALLOC_W*(ID_WIDTH+1)-1:0]  alloc_id_o,
  input  logic [$clog2(RETIRE_W+1)-1:0]    retire_cnt_i,
  input  logic                             flush_i,
`ifdef ROB_ID_PARTIAL_FLUSH_EN
  input  logic [ID_WIDTH:0]                flush_id_i,
`endif
  output logic [ID_WIDTH:0]                head_id_o,
  output logic [ID_WIDTH:0]                tail_id_o,
  output logic [ID_WIDTH:0]                count_o,
  output logic                             full_o,
  output logic                             empty_o
);

  localparam int unsigned PW    = ID_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ID_WIDTH;

  logic [PW-1:0] w_head;
  logic [PW-1:0] w_tail;
  logic [PW-1:0] w_count;
  logic [PW-1:0] w_free;
  logic [PW-1:0] w_alloc_n;
  logic [PW-1:0] w_retire_n;
  logic [PW-1:0] w_head_next;
  logic [PW-1:0] w_tail_inc;
  logic [PW-1:0] w_tail_ld_val;
  logic          w_alloc_rdy;
  logic          w_fire;

  // The wrap bit makes tail - head exact over the full range 0..DEPTH.
  assign w_count     = w_tail - w_head;
  assign w_free      = PW'(DEPTH) - w_count;
  assign w_alloc_rdy = (w_free >= PW'(ALLOC_W));

  // Count the requested lanes. A legal request is contiguous from lane 0.
  always_comb begin
    w_alloc_n = '0;
    for (int k = 0; k < ALLOC_W; k++) begin
      w_alloc_n = w_alloc_n + PW'(alloc_vld_i[k]);
    end
  end

  // Never retire more IDs than are live.
  assign w_retire_n  = (PW'(retire_cnt_i) > w_count) ? w_count : PW'(retire_cnt_i);
  assign w_head_next = w_head + w_retire_n;

  // A request is taken only when there is room for a full-width one.
  // Otherwise the whole request is dropped.
  assign w_fire     = w_alloc_rdy & ~flush_i;
  assign w_tail_inc = w_fire ? w_alloc_n : '0;

`ifdef ROB_ID_PARTIAL_FLUSH_EN
  assign w_tail_ld_val = flush_id_i + PW'(1);
`else
  assign w_tail_ld_val = w_head_next;
`endif

  rob_ptr_reg #(.W(PW)) u_head (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .inc_i    (w_retire_n),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .ptr_o    (w_head)
  );

  rob_ptr_reg #(.W(PW)) u_tail (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .inc_i    (w_tail_inc),
    .ld_i     (flush_i),
    .ld_val_i (w_tail_ld_val),
    .ptr_o    (w_tail)
  );

  // Lane IDs are valid every cycle, whether or not a lane is requested.
  for (genvar k = 0; k < ALLOC_W; k++) begin : g_lane
    assign alloc_id_o[k*PW +: PW] = w_tail + PW'(k);
  end

  assign alloc_rdy_o = w_alloc_rdy;
  assign head_id_o   = w_head;
  assign tail_id_o   = w_tail;
  assign count_o     = w_count;
  assign full_o      = (w_count == PW'(DEPTH));
  assign empty_o     = (w_count == '0);

`ifndef SYNTHESIS
  a_alloc_contig: assert property (@(posedge clk_i) disable iff (rst_i)
    ((alloc_vld_i & (alloc_vld_i + ALLOC_W'(1))) == '0))
    else $error("alloc_vld_i not contiguous from lane 0");

  a_retire_le_count: assert property (@(posedge clk_i) disable iff (rst_i)
    (PW'(retire_cnt_i) <= w_count))
    else $error("retire_cnt_i exceeds live count");

`ifdef ROB_ID_PARTIAL_FLUSH_EN
  // flush_id_i must lie in the window [head_next, tail-1].
  a_flush_id_range: assert property (@(posedge clk_i) disable iff (rst_i)
    flush_i |-> (PW'(flush_id_i - w_head_next) < PW'(w_tail - w_head_next)))
    else $error("flush_id_i outside live window");
`endif
`endif

endmodule

// File: tb/tb_rob_id_alloc.sv
// tb_rob_id_alloc: directed stimulus for rob_id_alloc (ID_WIDTH=3, ALLOC_W=2, RETIRE_W=2).
// A model on unbounded integer head and tail counts is compared against the DUT
// on every negedge. Hand-computed literal checks follow each directed step.
module tb_rob_id_alloc;

  logic       clk;
  logic       rst;
  logic [1:0] alloc_vld;
  logic       alloc_rdy;
  logic [7:0] alloc_id;
  logic [1:0] retire_cnt;
  logic       flush;
  logic [3:0] flush_id;
  logic [3:0] head_id;
  logic [3:0] tail_id;
  logic [3:0] count;
  logic       full;
  logic       empty;

  int total = 0;
  int bad   = 0;

  rob_id_alloc #(.ID_WIDTH(3), .ALLOC_W(2), .RETIRE_W(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .alloc_vld_i  (alloc_vld),
    .alloc_rdy_o  (alloc_rdy),
    .alloc_id_o   (alloc_id),
    .retire_cnt_i (retire_cnt),
    .flush_i      (flush),
`ifdef ROB_ID_PARTIAL_FLUSH_EN
    .flush_id_i   (flush_id),
`endif
    .head_id_o    (head_id),
    .tail_id_o    (tail_id),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: absolute allocation and retirement counts. The 4-bit {wrap,idx}
  // IDs are these counts modulo 16.
  int m_h, m_t;
  bit m_valid = 1'b0;
  int s_cnt, s_r, s_nh, s_nt;

  always @(posedge clk) begin
    if (rst) begin
      m_h     <= 0;
      m_t     <= 0;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      s_cnt = m_t - m_h;
      s_r   = (int'(retire_cnt) > s_cnt) ? s_cnt : int'(retire_cnt);
      s_nh  = m_h + s_r;
      if (flush) begin
`ifdef ROB_ID_PARTIAL_FLUSH_EN
        s_nt = s_nh + ((int'(flush_id) - (s_nh % 16) + 16) % 16) + 1;
`else
        s_nt = s_nh;
`endif
      end else if ((8 - s_cnt) >= 2) begin
        s_nt = m_t + $countones(alloc_vld);
      end else begin
        s_nt = m_t;
      end
      m_h <= s_nh;
      m_t <= s_nt;
    end
  end

  // Compare every DUT output against the model on every negedge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_count", int'(count), m_t - m_h);
      chk("m_full", int'(full), int'((m_t - m_h) == 8));
      chk("m_empty", int'(empty), int'((m_t - m_h) == 0));
      chk("m_rdy", int'(alloc_rdy), int'((8 - (m_t - m_h)) >= 2));
      chk("m_head", int'(head_id), m_h % 16);
      chk("m_tail", int'(tail_id), m_t % 16);
      chk("m_lane0", int'(alloc_id[3:0]), m_t % 16);
      chk("m_lane1", int'(alloc_id[7:4]), (m_t + 1) % 16);
    end
  end

  // Drive one cycle of inputs, then return 1 time unit after the consuming edge.
  task automatic cyc(input logic [1:0] v, input logic [1:0] r, input logic f);
    alloc_vld  = v;
    retire_cnt = r;
    flush      = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; alloc_vld = '0; retire_cnt = '0; flush = 1'b0; flush_id = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_rdy", int'(alloc_rdy), 1);
    chk("rst_ids", int'(alloc_id), 8'h10);
    chk("rst_head", int'(head_id), 0);
    chk("rst_tail", int'(tail_id), 0);
    rst = 1'b0;

    // Fill the ROB in pairs.
    for (int i = 0; i < 4; i++) begin
      chk("fill_ids", int'(alloc_id), ((2*i + 1) << 4) | (2*i));
      cyc(2'b11, 2'd0, 1'b0);
    end
    chk("fill_count", int'(count), 8);
    chk("fill_full", int'(full), 1);
    chk("fill_rdy", int'(alloc_rdy), 0);

    // Drain everything, then allocate past the wrap point.
    repeat (4) cyc(2'b00, 2'd2, 1'b0);
    chk("drain_empty", int'(empty), 1);
    chk("drain_head", int'(head_id), 8);
    chk("wrap_ids", int'(alloc_id), 8'h98);
    cyc(2'b11, 2'd0, 1'b0);
    chk("wrap_count", int'(count), 2);
    chk("wrap_head", int'(head_id), 8);
    chk("wrap_tail", int'(tail_id), 10);
    chk("wrap_empty", int'(empty), 0);
    chk("wrap_full", int'(full), 0);

    // Reset takes priority over alloc, retire and flush.
    rst = 1'b1;
    cyc(2'b11, 2'd1, 1'b1);
    rst = 1'b0;
    chk("rdom_head", int'(head_id), 0);
    chk("rdom_tail", int'(tail_id), 0);
    chk("rdom_count", int'(count), 0);

    // At count 7 a request is dropped until a retire frees room.
    repeat (3) cyc(2'b11, 2'd0, 1'b0);
    chk("c6_rdy", int'(alloc_rdy), 1);
    cyc(2'b01, 2'd0, 1'b0);
    chk("c7_count", int'(count), 7);
    chk("c7_rdy", int'(alloc_rdy), 0);
    cyc(2'b01, 2'd0, 1'b0);
    chk("drop_tail", int'(tail_id), 7);
    chk("drop_count", int'(count), 7);
    cyc(2'b00, 2'd1, 1'b0);
    chk("ret1_count", int'(count), 6);
    chk("ret1_rdy", int'(alloc_rdy), 1);

    // Simultaneous allocate and retire at count 4.
    cyc(2'b00, 2'd2, 1'b0);
    chk("c4_count", int'(count), 4);
    cyc(2'b11, 2'd2, 1'b0);
    chk("sim_count", int'(count), 4);
    chk("sim_head", int'(head_id), 5);
    chk("sim_tail", int'(tail_id), 9);

    // Flush with a concurrent retire and alloc at head=3, tail=9.
    rst = 1'b1;
    cyc(2'b00, 2'd0, 1'b0);
    rst = 1'b0;
    repeat (3) cyc(2'b11, 2'd0, 1'b0);
    cyc(2'b11, 2'd2, 1'b0);
    cyc(2'b01, 2'd1, 1'b0);
    chk("pf_head", int'(head_id), 3);
    chk("pf_tail", int'(tail_id), 9);
    flush_id = 4'd4;
    cyc(2'b11, 2'd1, 1'b1);
    chk("fl_head", int'(head_id), 4);
`ifdef ROB_ID_PARTIAL_FLUSH_EN
    chk("fl_tail", int'(tail_id), 5);
    chk("fl_count", int'(count), 1);
`else
    chk("fl_tail", int'(tail_id), 4);
    chk("fl_empty", int'(empty), 1);
`endif

`ifdef ROB_ID_PARTIAL_FLUSH_EN
    // Partial flush at head=2, tail=7, flush_id=4.
    rst = 1'b1;
    cyc(2'b00, 2'd0, 1'b0);
    rst = 1'b0;
    repeat (3) cyc(2'b11, 2'd0, 1'b0);
    cyc(2'b01, 2'd0, 1'b0);
    cyc(2'b00, 2'd2, 1'b0);
    flush_id = 4'd4;
    cyc(2'b00, 2'd0, 1'b1);
    chk("pfl_tail", int'(tail_id), 5);
    chk("pfl_count", int'(count), 3);
`endif

    cyc(2'b00, 2'd0, 1'b0);
    cyc(2'b00, 2'd0, 1'b0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
